// File: rtl/uart_rx_byte.sv
// ----------------------------------------------------------------------------
// uart_rx_byte
//   Oversampling 8N1 UART receiver running directly on the system clock.
//   The asynchronous rx pin passes through a two-flop synchroniser. The
//   start bit is re-checked at its midpoint, and each data/stop bit is
//   sampled one bit time after the previous sample point. A completed byte
//   is parked in a one-entry holding register behind a valid/ready
//   handshake. This block feeds the instruction-assembly stage.
//
// Parameters
//   CLKS_PER_BIT : system clocks per serial bit (>= 4)
//
// Ports
//   clk       in   system clock, all state on rising edge
//   rst_n     in   asynchronous active-low reset
//   rx        in   serial line, idle high, asynchronous to clk
//   rx_data   out  received byte, stable while rx_valid is high
//   rx_valid  out  holding register full
//   rx_ready  in   consumer takes the byte when rx_valid && rx_ready
//   frame_err out  one-cycle pulse: stop bit sampled low
//   overrun   out  one-cycle pulse: finished byte dropped, holding reg full
//   busy      out  receiver FSM is outside IDLE
// ----------------------------------------------------------------------------
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 1086
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    logic          r_rx_meta;
    logic          r_rx_sync;
    logic          w_rx_s;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    r_bit_idx;
    logic [2:0]    w_bit_idx_nxt;
    logic [7:0]    r_sr;
    logic [7:0]    w_sr_nxt;
    logic          w_deliver;
    logic          w_stop_bad;
    logic          w_accept;

    assign w_rx_s   = r_rx_sync;
    assign w_accept = rx_valid && rx_ready;

    // Two-flop synchroniser for the asynchronous rx pin; resets to line-idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // FSM state plus bit counter, bit index and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= CNT_ZERO;
            r_bit_idx <= 3'd0;
            r_sr      <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_sr      <= w_sr_nxt;
        end
    end

    // Next-state logic and the per-bit sampling decisions.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_sr_nxt      = r_sr;
        w_deliver     = 1'b0;
        w_stop_bad    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = CNT_ZERO;
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            // Re-check the line mid start bit; a high level means a glitch.
            S_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nxt = CNT_ZERO;
                    if (w_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt   = S_DATA;
                        w_bit_idx_nxt = 3'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            // LSB arrives first, so shift in from the top.
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt     = CNT_ZERO;
                    w_sr_nxt      = {w_rx_s, r_sr[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            // Leave mid stop bit so a back-to-back start edge is not missed.
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = CNT_ZERO;
                    if (w_rx_s) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_stop_bad  = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            // A break or stuck-low line must go high before a new frame.
            S_WAIT: begin
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Holding register, handshake, and single-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= w_stop_bad;
            overrun   <= 1'b0;
            busy      <= (w_state_nxt != S_IDLE);
            if (w_deliver) begin
                // A same-cycle consume frees the slot, so the new byte loads.
                if (!rx_valid || rx_ready) begin
                    rx_data  <= r_sr;
                    rx_valid <= 1'b1;
                end else begin
                    overrun  <= 1'b1;
                end
            end else if (w_accept) begin
                rx_valid <= 1'b0;
            end else begin
                rx_valid <= rx_valid;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_byte
//   Directed and randomized frames driven on rx at 16 clocks per bit. A
//   monitor records every handshake byte and status pulse. The expected
//   byte stream and pulse counts come from the frames the bench chose to
//   send.
// ----------------------------------------------------------------------------
module tb_uart_rx_byte;

    localparam int BIT = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor state, written only by the monitor process.
    logic [7:0] got_q[$];
    int valid_cycles = 0;
    int ferr_cnt     = 0;
    int ovr_cnt      = 0;
    int both_cnt     = 0;

    // Reference stream: bytes with a good stop bit, in send order.
    logic [7:0] exp_q[$];
    int rd_idx = 0;

    uart_rx_byte #(.CLKS_PER_BIT(BIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) valid_cycles++;
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (frame_err && overrun) both_cnt++;
        end
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One 8N1 frame, then low_after bit times held low, then gap idle bits.
    task automatic send_frame(input logic [7:0] b, input logic stop_b,
                              input int low_after, input int gap_bits);
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(BIT);
        end
        rx = stop_b;
        wait_clks(BIT);
        if (low_after > 0) begin
            rx = 1'b0;
            wait_clks(low_after * BIT);
        end
        rx = 1'b1;
        wait_clks(gap_bits * BIT);
    endtask

    // Compare all newly received bytes against the reference stream.
    task automatic check_stream(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (rd_idx < exp_q.size() && rd_idx < got_q.size()) begin
            check({tag, "_byte"}, {24'h0, got_q[rd_idx]}, {24'h0, exp_q[rd_idx]});
            rd_idx++;
        end
        rd_idx = exp_q.size();
    endtask

    initial begin
        int vc0, fe0, ov0;
        logic [7:0] rb;
        logic       rstop;
        int         rgap;
        int         k;

        rst_n    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b1;
        wait_clks(3);
        check("reset_rx_data",   {24'h0, rx_data}, 32'h0);
        check("reset_rx_valid",  {31'h0, rx_valid}, 32'h0);
        check("reset_frame_err", {31'h0, frame_err}, 32'h0);
        check("reset_overrun",   {31'h0, overrun}, 32'h0);
        check("reset_busy",      {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        wait_clks(BIT);

        // 1: single frame with consumer ready.
        vc0 = valid_cycles; fe0 = ferr_cnt; ov0 = ovr_cnt;
        send_frame(8'h41, 1'b1, 0, 1);
        exp_q.push_back(8'h41);
        check("t1_valid_cycles", valid_cycles - vc0, 32'd1);
        check("t1_ferr", ferr_cnt - fe0, 32'd0);
        check("t1_ovr", ovr_cnt - ov0, 32'd0);
        check_stream("t1");

        // 2: glitch shorter than half a bit.
        vc0 = valid_cycles; fe0 = ferr_cnt;
        rx = 1'b0;
        wait_clks(4);
        rx = 1'b1;
        k = 0;
        while (k < 10 && busy !== 1'b0) begin
            wait_clks(1);
            k++;
        end
        check("t2_busy_idle", {31'h0, busy}, 32'h0);
        wait_clks(BIT);
        check("t2_no_valid", valid_cycles - vc0, 32'd0);
        check("t2_no_ferr", ferr_cnt - fe0, 32'd0);

        // 3: framing error with a held-low line, then a clean frame.
        fe0 = ferr_cnt; ov0 = ovr_cnt;
        send_frame(8'h55, 1'b0, 3, 1);
        check("t3_ferr", ferr_cnt - fe0, 32'd1);
        send_frame(8'hA5, 1'b1, 0, 1);
        exp_q.push_back(8'hA5);
        check("t3_ferr_total", ferr_cnt - fe0, 32'd1);
        check("t3_ovr", ovr_cnt - ov0, 32'd0);
        check_stream("t3");

        // 4: overrun while the holding register stays full.
        rx_ready = 1'b0;
        ov0 = ovr_cnt;
        send_frame(8'h11, 1'b1, 0, 1);
        check("t4_valid_first", {31'h0, rx_valid}, 32'h1);
        check("t4_data_first", {24'h0, rx_data}, 32'h11);
        send_frame(8'h22, 1'b1, 0, 1);
        check("t4_overrun", ovr_cnt - ov0, 32'd1);
        check("t4_data_held", {24'h0, rx_data}, 32'h11);
        check("t4_valid_held", {31'h0, rx_valid}, 32'h1);
        rx_ready = 1'b1;
        wait_clks(1);
        check("t4_valid_drop", {31'h0, rx_valid}, 32'h0);
        exp_q.push_back(8'h11);
        check_stream("t4");

        // 5: back-to-back frames with no idle gap.
        fe0 = ferr_cnt; ov0 = ovr_cnt;
        send_frame(8'h01, 1'b1, 0, 0);
        send_frame(8'h02, 1'b1, 0, 0);
        send_frame(8'h03, 1'b1, 0, 0);
        send_frame(8'h04, 1'b1, 0, 1);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h04);
        check("t5_ferr", ferr_cnt - fe0, 32'd0);
        check("t5_ovr", ovr_cnt - ov0, 32'd0);
        check_stream("t5");

        // Random frames: random data, occasional bad stop, random gaps.
        fe0 = ferr_cnt; ov0 = ovr_cnt;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            rb    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 3) != 0);
            rgap  = rstop ? $urandom_range(0, 2) : $urandom_range(1, 2);
            send_frame(rb, rstop, 0, rgap);
            if (rstop) exp_q.push_back(rb);
            else k++;
        end
        wait_clks(4);
        check("rnd_ferr", ferr_cnt - fe0, k);
        check("rnd_ovr", ovr_cnt - ov0, 32'd0);
        check_stream("rnd");

        // 6: reset in the middle of data bit 3.
        rx = 1'b0;
        wait_clks(BIT);
        rx = 1'b1; wait_clks(BIT);
        rx = 1'b1; wait_clks(BIT);
        rx = 1'b0; wait_clks(BIT);
        rx = 1'b1; wait_clks(BIT / 2);
        check("t6_busy_mid", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_clks(2);
        check("t6_rst_data",  {24'h0, rx_data}, 32'h0);
        check("t6_rst_valid", {31'h0, rx_valid}, 32'h0);
        check("t6_rst_busy",  {31'h0, busy}, 32'h0);
        check("t6_rst_ferr",  {31'h0, frame_err}, 32'h0);
        rst_n = 1'b1;
        wait_clks(2 * BIT);
        fe0 = ferr_cnt;
        send_frame(8'hC3, 1'b1, 0, 1);
        exp_q.push_back(8'hC3);
        check("t6_ferr", ferr_cnt - fe0, 32'd0);
        check_stream("t6");

        check("never_both_pulses", both_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
